// File: rtl/elevador_pkg.sv
// Shared definitions for the elevator request-service controller: state
// encoding, default timings, floor width and the empty request-slot marker.
package elevador_pkg;

  localparam int ANDAR_W        = 4;
  localparam int TEMPO_W        = 16;
  localparam int T_ANDAR_PADRAO = 4;
  localparam int T_PORTA_PADRAO = 8;

  localparam logic [7:0]         SLOT_VAZIO = 8'h00;
  localparam logic [ANDAR_W-1:0] ANDAR_MAX  = '1;

  typedef enum logic [3:0] {
    INICIAL,
    BUSCA,
    LE,
    AVALIA,
    MOVE_ORIGEM,
    PORTA_ORIGEM,
    MOVE_DESTINO,
    PORTA_DESTINO,
    LIBERA
  } estado_t;

  // One floor step toward the target, clamped to the building limits.
  function automatic logic [ANDAR_W-1:0] proximo_andar(input logic [ANDAR_W-1:0] atual,
                                                       input logic [ANDAR_W-1:0] alvo);
    if (alvo > atual && atual != ANDAR_MAX) return atual + 1'b1;
    if (alvo < atual && atual != '0) return atual - 1'b1;
    return atual;
  endfunction

endpackage

// File: rtl/contador_tempo.sv
// Down-counter that times both floor travel and door-open periods.
// Loading N-1 makes done rise after exactly N cycles in the loaded state.
module contador_tempo
  import elevador_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               enable,
  input  logic [TEMPO_W-1:0] valor,
  output logic               done
);

  logic [TEMPO_W-1:0] restante;

  always_ff @(posedge clock) begin
    if (reset) begin
      restante <= '0;
    end else if (load) begin
      restante <= valor;
    end else if (enable && restante != '0) begin
      restante <= restante - 1'b1;
    end
  end

  assign done = (restante == '0);

endmodule

// File: rtl/uc_atendimento.sv
// Elevator control unit: scans a 16-slot request RAM, carries the car to the
// request origin and destination with timed door openings, then frees the slot.
module uc_atendimento
  import elevador_pkg::*;
#(
  parameter int T_ANDAR = T_ANDAR_PADRAO,
  parameter int T_PORTA = T_PORTA_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [7:0] ramDado,
  output logic [3:0] ramEndereco,
  output logic       ramWe,
  output logic [3:0] andarAtual,
  output logic       subindo,
  output logic       descendo,
  output logic       portaAberta,
  output logic       ocupado,
  output logic       atendido
);

  localparam logic [TEMPO_W-1:0] CARGA_ANDAR = TEMPO_W'(T_ANDAR - 1);
  localparam logic [TEMPO_W-1:0] CARGA_PORTA = TEMPO_W'(T_PORTA - 1);

  estado_t            estado;
  logic [ANDAR_W-1:0] origem;
  logic [ANDAR_W-1:0] destino;
  logic [ANDAR_W-1:0] alvo;
  logic [ANDAR_W-1:0] proximo;
  logic               t_load;
  logic               t_enable;
  logic               t_done;
  logic [TEMPO_W-1:0] t_valor;

  assign alvo    = (estado == MOVE_ORIGEM) ? origem : destino;
  assign proximo = proximo_andar(andarAtual, alvo);

  contador_tempo u_tempo (
    .clock  (clock),
    .reset  (reset),
    .load   (t_load),
    .enable (t_enable),
    .valor  (t_valor),
    .done   (t_done)
  );

  // Arriving on the target floor reloads the timer for the door directly, so
  // the door period follows the last travel step with no idle cycle.
  always_comb begin
    t_load   = 1'b0;
    t_enable = 1'b0;
    t_valor  = CARGA_ANDAR;
    case (estado)
      AVALIA: t_load = (ramDado != SLOT_VAZIO);
      MOVE_ORIGEM, MOVE_DESTINO: begin
        if (andarAtual == alvo) begin
          t_load  = 1'b1;
          t_valor = CARGA_PORTA;
        end else if (t_done) begin
          t_load  = 1'b1;
          t_valor = (proximo == alvo) ? CARGA_PORTA : CARGA_ANDAR;
        end else begin
          t_enable = 1'b1;
        end
      end
      PORTA_ORIGEM: begin
        if (t_done) t_load = 1'b1;
        else        t_enable = 1'b1;
      end
      PORTA_DESTINO: t_enable = !t_done;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado      <= INICIAL;
      ramEndereco <= '0;
      ramWe       <= 1'b0;
      andarAtual  <= '0;
      subindo     <= 1'b0;
      descendo    <= 1'b0;
      portaAberta <= 1'b0;
      ocupado     <= 1'b0;
      atendido    <= 1'b0;
      origem      <= '0;
      destino     <= '0;
    end else begin
      ramWe    <= 1'b0;
      atendido <= 1'b0;
      case (estado)
        INICIAL: if (iniciar) estado <= BUSCA;
        BUSCA:   estado <= LE;
        LE:      estado <= AVALIA;
        AVALIA: begin
          if (ramDado == SLOT_VAZIO) begin
            ramEndereco <= ramEndereco + 1'b1;
            estado      <= BUSCA;
          end else begin
            origem   <= ramDado[7:4];
            destino  <= ramDado[3:0];
            ocupado  <= 1'b1;
            subindo  <= (ramDado[7:4] > andarAtual);
            descendo <= (ramDado[7:4] < andarAtual);
            estado   <= MOVE_ORIGEM;
          end
        end
        MOVE_ORIGEM, MOVE_DESTINO: begin
          if (t_done && andarAtual != alvo) andarAtual <= proximo;
          if (andarAtual == alvo || (t_done && proximo == alvo)) begin
            subindo     <= 1'b0;
            descendo    <= 1'b0;
            portaAberta <= 1'b1;
            estado      <= (estado == MOVE_ORIGEM) ? PORTA_ORIGEM : PORTA_DESTINO;
          end
        end
        PORTA_ORIGEM: begin
          if (t_done) begin
            portaAberta <= 1'b0;
            subindo     <= (destino > andarAtual);
            descendo    <= (destino < andarAtual);
            estado      <= MOVE_DESTINO;
          end
        end
        PORTA_DESTINO: begin
          if (t_done) begin
            portaAberta <= 1'b0;
            ramWe       <= 1'b1;
            atendido    <= 1'b1;
            estado      <= LIBERA;
          end
        end
        LIBERA: begin
          ocupado     <= 1'b0;
          ramEndereco <= ramEndereco + 1'b1;
          estado      <= BUSCA;
        end
        default: estado <= INICIAL;
      endcase
    end
  end

endmodule

// File: doc/uc_atendimento.md
UC_ATENDIMENTO -- requirements
Module: uc_atendimento

Interface
REQ-001 SHALL have parameter T_ANDAR, default 4: clock cycles to travel one floor.
REQ-002 SHALL have parameter T_PORTA, default 8: clock cycles the door stays open.
REQ-003 SHALL have port clock, input, 1: single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port iniciar, input, 1: starts request service from state INICIAL.
REQ-006 SHALL have port ramDado, input, 8: request-RAM read data {origem[7:4], destino[3:0]}; 8'h00 marks an empty slot.
REQ-007 SHALL have port ramEndereco, output, 4: request-RAM address.
REQ-008 SHALL have port ramWe, output, 1: one-cycle write strobe that writes 8'h00 to ramEndereco (slot release).
REQ-009 SHALL have port andarAtual, output, 4: current car floor, 0..15.
REQ-010 SHALL have port subindo, output, 1: car moving up.
REQ-011 SHALL have port descendo, output, 1: car moving down.
REQ-012 SHALL have port portaAberta, output, 1: door open.
REQ-013 SHALL have port ocupado, output, 1: a request is being served.
REQ-014 SHALL have port atendido, output, 1: one-cycle pulse when a request is completed.

Function
REQ-015 SHALL implement states INICIAL, BUSCA, LE, AVALIA, MOVE_ORIGEM, PORTA_ORIGEM, MOVE_DESTINO, PORTA_DESTINO, LIBERA.
REQ-016 SHALL transition INICIAL->BUSCA when iniciar=1 and remain in INICIAL otherwise.
REQ-017 SHALL drive ramEndereco in BUSCA, then wait in LE for the 1-cycle synchronous RAM latency, and sample ramDado in AVALIA.
REQ-018 SHALL, in AVALIA on ramDado=8'h00, increment ramEndereco modulo 16 (15->0) and return to BUSCA; scanning continues indefinitely while ocupado=0.
REQ-019 SHALL, in AVALIA on non-empty ramDado, latch origem and destino, hold ramEndereco, set ocupado=1, and go to MOVE_ORIGEM.
REQ-020 SHALL, in MOVE states, change andarAtual by +/-1 every T_ANDAR cycles toward the target, with subindo/descendo asserted accordingly and never both asserted.
REQ-021 SHALL exit MOVE_ORIGEM to PORTA_ORIGEM when andarAtual equals origem; when origem already equals andarAtual on entry, this SHALL take exactly 1 cycle with no floor change.
REQ-022 SHALL assert portaAberta for exactly T_PORTA cycles in each PORTA state, then continue to the next state.
REQ-023 SHALL handle destino==origem by completing MOVE_DESTINO in 1 cycle, followed by a full PORTA_DESTINO period.
REQ-024 SHALL, in LIBERA, assert ramWe and atendido for exactly one cycle, clear ocupado, increment ramEndereco modulo 16, and go to BUSCA.
REQ-025 SHALL ignore iniciar outside INICIAL.
REQ-026 SHALL treat andarAtual as saturating to 0..15, with no wrap-around.
REQ-027 SHALL not re-sample ramDado between AVALIA and LIBERA; the latched request governs.

Reset
REQ-028 SHALL, on reset=1 at a clock edge in any state (including mid-move or with the door open), set state INICIAL, ramEndereco=0, andarAtual=0, ramWe=0, subindo=0, descendo=0, portaAberta=0, ocupado=0, atendido=0, and clear the timers and latched request.
REQ-029 SHALL give reset priority over every other input.

Structure
REQ-030 SHALL place the state encoding, T_ANDAR/T_PORTA defaults, the empty-slot constant 8'h00 and the floor width (4) in shared package elevador_pkg.
REQ-031 SHALL implement the T_ANDAR/T_PORTA countdown in one sub-module, contador_tempo (load, enable, done), shared by the MOVE and PORTA states.

Verification
REQ-032 SHALL verify that with all 16 slots 8'h00 after iniciar, ramEndereco cycles 0..15->0 with ocupado=0 and ramWe never asserted.
REQ-033 SHALL verify that slot 3=8'h25 with car at floor 0 produces subindo for 8 cycles (andarAtual 0->2), then portaAberta for 8 cycles, subindo for 12 cycles (2->5), portaAberta for 8 cycles, then ramWe+atendido at address 3 for 1 cycle.
REQ-034 SHALL verify that slot 0=8'h50 with car at floor 0 produces subindo to 5, then descendo 5->0, with subindo and descendo never both 1.
REQ-035 SHALL verify that slot 7=8'h00 followed by slot 8=8'h33 with car at floor 3 produces no movement, two door periods, and ramWe at address 8.
REQ-036 SHALL verify that reset asserted during MOVE_DESTINO at andarAtual=4 gives, on the next cycle, all outputs at reset values and state INICIAL.
REQ-037 SHALL verify that a request in slot 15 is served, the slot is cleared, and the scan resumes at address 0.
